// File: rtl/debounce_botao_pkg.sv
// Shared definitions for the board push-button conditioning stages.
// State encoding and default timing constants reused by every button front end.
package debounce_botao_pkg;

    typedef enum logic [1:0] {
        ESTAVEL_BAIXO = 2'b00,
        CONF_ALTA     = 2'b01,
        ESTAVEL_ALTO  = 2'b10,
        CONF_BAIXA    = 2'b11
    } estadoT;

    // 10 ms of confirmation at a 50 MHz system clock.
    localparam int CICLOS_ESTAVEL_PADRAO = 500000;
    localparam int SYNC_STAGES_PADRAO    = 2;

endpackage

// File: rtl/debounce_botao_sincronizador.sv
// Multi-flop synchroniser for asynchronous board inputs, with a configurable
// reset level so idle buttons read correctly straight out of reset.
module sincronizador
    import debounce_botao_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_PADRAO,
    parameter logic VALOR_RESET = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic saida
);

    logic [SYNC_STAGES-1:0] cadeia;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cadeia <= {SYNC_STAGES{VALOR_RESET}};
        end else begin
            cadeia <= {cadeia[SYNC_STAGES-2:0], entrada};
        end
    end

    assign saida = cadeia[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_botao.sv
// Push-button debouncer: synchronise, confirm a new level for CICLOS_ESTAVEL cycles,
// then emit a clean level plus rise/fall strobes. Define BOTAO_INVERTIDO_EN for active-low pads.
module debounce_botao
    import debounce_botao_pkg::*;
#(
    parameter  int CICLOS_ESTAVEL = CICLOS_ESTAVEL_PADRAO,
    parameter  int SYNC_STAGES    = SYNC_STAGES_PADRAO,
    localparam int LARG_CONT      = $clog2(CICLOS_ESTAVEL)
) (
    input  logic clock,
    input  logic reset,
    input  logic botaoPlaca,
    output logic botaoLimpo,
    output logic subida,
    output logic descida
);

    localparam logic [LARG_CONT-1:0] CONT_MAX = LARG_CONT'(CICLOS_ESTAVEL - 1);
    localparam logic [LARG_CONT-1:0] CONT_UM  = LARG_CONT'(1);

`ifdef BOTAO_INVERTIDO_EN
    localparam logic NIVEL_REPOUSO = 1'b1;
`else
    localparam logic NIVEL_REPOUSO = 1'b0;
`endif

    logic ultimoEstagio;
    logic amostra;

    sincronizador #(
        .SYNC_STAGES (SYNC_STAGES),
        .VALOR_RESET (NIVEL_REPOUSO)
    ) uSinc (
        .clock   (clock),
        .reset   (reset),
        .entrada (botaoPlaca),
        .saida   (ultimoEstagio)
    );

`ifdef BOTAO_INVERTIDO_EN
    assign amostra = ~ultimoEstagio;
`else
    assign amostra = ultimoEstagio;
`endif

    estadoT               estado, estadoProx;
    logic [LARG_CONT-1:0] cont, contProx;
    logic                 limpoProx, subidaProx, descidaProx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= ESTAVEL_BAIXO;
            cont       <= '0;
            botaoLimpo <= 1'b0;
            subida     <= 1'b0;
            descida    <= 1'b0;
        end else begin
            estado     <= estadoProx;
            cont       <= contProx;
            botaoLimpo <= limpoProx;
            subida     <= subidaProx;
            descida    <= descidaProx;
        end
    end

    // Counter counts consecutive samples at the candidate level; any disagreement aborts.
    always_comb begin
        estadoProx  = estado;
        contProx    = cont;
        limpoProx   = botaoLimpo;
        subidaProx  = 1'b0;
        descidaProx = 1'b0;
        case (estado)
            ESTAVEL_BAIXO: begin
                if (amostra) begin
                    estadoProx = CONF_ALTA;
                    contProx   = CONT_UM;
                end else begin
                    contProx   = '0;
                end
            end
            CONF_ALTA: begin
                if (!amostra) begin
                    estadoProx = ESTAVEL_BAIXO;
                    contProx   = '0;
                end else if (cont == CONT_MAX) begin
                    estadoProx = ESTAVEL_ALTO;
                    contProx   = '0;
                    limpoProx  = 1'b1;
                    subidaProx = 1'b1;
                end else begin
                    contProx   = cont + CONT_UM;
                end
            end
            ESTAVEL_ALTO: begin
                if (!amostra) begin
                    estadoProx = CONF_BAIXA;
                    contProx   = CONT_UM;
                end else begin
                    contProx   = '0;
                end
            end
            CONF_BAIXA: begin
                if (amostra) begin
                    estadoProx  = ESTAVEL_ALTO;
                    contProx    = '0;
                end else if (cont == CONT_MAX) begin
                    estadoProx  = ESTAVEL_BAIXO;
                    contProx    = '0;
                    limpoProx   = 1'b0;
                    descidaProx = 1'b1;
                end else begin
                    contProx    = cont + CONT_UM;
                end
            end
            default: begin
                estadoProx = ESTAVEL_BAIXO;
                contProx   = '0;
                limpoProx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce_botao.sv
// Self-checking bench for debounce_botao: directed cases plus random bouncing input,
// checked against a run-length reference model of the debounce rule.
module tb_debounce_botao;

    localparam int CICLOS = 4;
    localparam int SYNC   = 2;

`ifdef BOTAO_INVERTIDO_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic botaoPlaca = INV;
    logic botaoLimpo, subida, descida;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clock = ~clock;

    debounce_botao #(
        .CICLOS_ESTAVEL (CICLOS),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .botaoPlaca (botaoPlaca),
        .botaoLimpo (botaoLimpo),
        .subida     (subida),
        .descida    (descida)
    );

    // Reference: the level seen SYNC edges late must disagree with the clean level
    // for CICLOS consecutive edges before the clean level flips.
    logic hist[$];
    logic nivelM, subM, desM, amostraM;
    int   runM;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_front(INV);
            nivelM = 1'b0;
            subM   = 1'b0;
            desM   = 1'b0;
            runM   = 0;
        end else begin
            amostraM = hist[SYNC-1] ^ INV;
            hist.push_front(botaoPlaca);
            void'(hist.pop_back());
            subM = 1'b0;
            desM = 1'b0;
            if (amostraM != nivelM) begin
                runM = runM + 1;
                if (runM == CICLOS) begin
                    nivelM = ~nivelM;
                    subM   = nivelM;
                    desM   = ~nivelM;
                    runM   = 0;
                end
            end else begin
                runM = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        nChecks = nChecks + 1;
        assert (obs === exp) nPass = nPass + 1;
        else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic checkModel(input string fase);
        chk({fase, " botaoLimpo"}, botaoLimpo, nivelM);
        chk({fase, " subida"}, subida, subM);
        chk({fase, " descida"}, descida, desM);
        chk({fase, " exclusivo"}, subida & descida, 1'b0);
    endtask

    // Drive a logical button level (pad polarity handled here), one clock edge.
    task automatic step(input logic v, input string fase);
        botaoPlaca = v ^ INV;
        @(posedge clock);
        @(negedge clock);
        checkModel(fase);
    endtask

    initial begin
        #2 reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            botaoPlaca = 1'($urandom_range(0, 1));
            @(posedge clock);
            @(negedge clock);
            chk("rst botaoLimpo", botaoLimpo, 1'b0);
            chk("rst subida", subida, 1'b0);
            chk("rst descida", descida, 1'b0);
        end

        botaoPlaca = INV;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, "pos-reset");

        for (int i = 1; i <= 10; i++) begin
            step(1'b1, "press");
            chk("press subida edge", subida, 1'(i == 6));
            chk("press descida", descida, 1'b0);
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, "release");
            chk("release descida edge", descida, 1'(i == 6));
        end
        chk("release nivel", botaoLimpo, 1'b0);

        for (int i = 0; i < 3; i++) step(1'b1, "bounce");
        step(1'b0, "bounce");
        for (int i = 0; i < 3; i++) step(1'b1, "bounce");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, "bounce");
            chk("bounce nivel", botaoLimpo, 1'b0);
        end

        for (int i = 0; i < 4; i++) step(1'b1, "mid-conf");
        reset = 1'b0;
        #1;
        chk("mid reset botaoLimpo", botaoLimpo, 1'b0);
        chk("mid reset subida", subida, 1'b0);
        chk("mid reset descida", descida, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, "restart");
            chk("restart subida edge", subida, 1'(i == 6));
        end
        for (int i = 0; i < 8; i++) step(1'b0, "restart-rel");

        for (int s = 0; s < 80; s++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * CICLOS);
            for (int k = 0; k < len; k++) step(v, "random");
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end expected finish");
        $fatal(1, "timeout");
    end

endmodule
